// File: rtl/fp4_pkg.sv
// Shared FP4 (E2M1) constants, operand word layout and job FSM encoding.
package fp4_pkg;

    // E2M1 encodings used by the streamer and its test environment.
    localparam logic [3:0] FP4_ZERO   = 4'b0000;
    localparam logic [3:0] FP4_ONE    = 4'b0010;
    localparam logic [3:0] FP4_ONE_P5 = 4'b0011;
    localparam logic [3:0] FP4_TWO    = 4'b0100;
    localparam logic [3:0] FP4_THREE  = 4'b0101;

    // Packed operand word: {a1, b1, a0, b0}.
    localparam int unsigned A1_MSB = 15;
    localparam int unsigned A1_LSB = 12;
    localparam int unsigned B1_MSB = 11;
    localparam int unsigned B1_LSB = 8;
    localparam int unsigned A0_MSB = 7;
    localparam int unsigned A0_LSB = 4;
    localparam int unsigned B0_MSB = 3;
    localparam int unsigned B0_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/fp4_operand_fifo.sv
// DEPTH x WIDTH synchronous FIFO holding packed operand words.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fp4_operand_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset discards all queued words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/fp4_mac_streamer.sv
// Start/done job sequencer in front of the dual-lane FP4 MAC: buffers operand
// words, clears the MAC at job start, streams len words, waits for the MAC
// pipeline to drain and captures both lane results.
module fp4_mac_streamer
    import fp4_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic [3:0]       a0,
    output logic [3:0]       b0,
    output logic [3:0]       a1,
    output logic [3:0]       b1,
    output logic             mac_clr,
    input  logic [3:0]       facc0_in,
    input  logic [3:0]       facc1_in,
    output logic [3:0]       res0,
    output logic [3:0]       res1,
    output logic             done
);

    localparam int unsigned DW = $clog2(MAC_LAT + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [DW-1:0]    r_drain;
    logic [DW-1:0]    w_drain_nxt;
    logic [15:0]      r_ops;
    logic [15:0]      w_ops_nxt;
    logic             r_mac_clr;
    logic             w_mac_clr_nxt;
    logic             r_done;
    logic [3:0]       r_res0;
    logic [3:0]       r_res1;
    logic             w_capture;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [15:0]      w_fifo_data;

    assign w_push    = in_valid && !w_full;
    assign w_cnt_inc = r_cnt + LEN_W'(1);

    fp4_operand_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (in_data),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state and next-value logic; mac_clr and operands are produced here
    // as next values so the outputs themselves come straight from flops.
    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_cnt_nxt     = r_cnt;
        w_drain_nxt   = r_drain;
        w_ops_nxt     = {4{FP4_ZERO}};
        w_mac_clr_nxt = 1'b0;
        w_pop         = 1'b0;
        w_capture     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start && (len != '0)) begin
                    w_len_nxt     = len;
                    w_cnt_nxt     = '0;
                    w_mac_clr_nxt = 1'b1;
                    w_state_nxt   = CLEAR;
                end
            end
            CLEAR: begin
                w_state_nxt = STREAM;
            end
            STREAM: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_ops_nxt = w_fifo_data;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_drain_nxt = DW'(MAC_LAT);
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (r_drain == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_drain_nxt = r_drain - DW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_drain   <= '0;
            r_ops     <= {4{FP4_ZERO}};
            r_mac_clr <= 1'b0;
            r_done    <= 1'b0;
            r_res0    <= FP4_ZERO;
            r_res1    <= FP4_ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_len     <= w_len_nxt;
            r_cnt     <= w_cnt_nxt;
            r_drain   <= w_drain_nxt;
            r_ops     <= w_ops_nxt;
            r_mac_clr <= w_mac_clr_nxt;
            r_done    <= w_capture;
            if (w_capture) begin
                r_res0 <= facc0_in;
                r_res1 <= facc1_in;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign in_ready = !w_full;
    assign mac_clr  = r_mac_clr;
    assign done     = r_done;
    assign res0     = r_res0;
    assign res1     = r_res1;
    assign a1       = r_ops[A1_MSB:A1_LSB];
    assign b1       = r_ops[B1_MSB:B1_LSB];
    assign a0       = r_ops[A0_MSB:A0_LSB];
    assign b0       = r_ops[B0_MSB:B0_LSB];

endmodule

// File: tb/tb_fp4_mac_streamer.sv
// Directed bench for fp4_mac_streamer with a behavioural dual-lane FP4 MAC
// attached to its operand outputs.
module tb_fp4_mac_streamer;
    import fp4_pkg::*;

    localparam int unsigned MAC_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  a0, b0, a1, b1;
    logic        mac_clr;
    logic [3:0]  facc0_in, facc1_in;
    logic [3:0]  res0, res1;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp4_mac_streamer #(
        .DEPTH   (4),
        .LEN_W   (8),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .mac_clr  (mac_clr),
        .facc0_in (facc0_in),
        .facc1_in (facc1_in),
        .res0     (res0),
        .res1     (res1),
        .done     (done)
    );

    // ---------------- behavioural MAC (values in units of 0.25) ----------
    function automatic int q4(input logic [3:0] c);
        int mag;
        case (c[2:1])
            2'd0:    mag = c[0] ? 2 : 0;
            2'd1:    mag = 4 + (c[0] ? 2 : 0);
            2'd2:    mag = 8 + (c[0] ? 4 : 0);
            default: mag = 16 + (c[0] ? 8 : 0);
        endcase
        return c[3] ? -mag : mag;
    endfunction

    function automatic logic [3:0] enc(input int q);
        logic       s;
        int         m;
        logic [2:0] c;
        s = (q < 0);
        m = s ? -q : q;
        c = '0;
        for (int i = 0; i < 8; i++)
            if (q4({1'b0, 3'(i)}) <= m) c = 3'(i);
        return {s, c};
    endfunction

    logic mrst;
    int   acc0, acc1;
    int   p0, p1;
    logic [3:0] pipe0 [MAC_LAT];
    logic [3:0] pipe1 [MAC_LAT];

    assign mrst = rst | mac_clr;
    assign p0   = q4(a0) * q4(b0) / 4;
    assign p1   = q4(a1) * q4(b1) / 4;

    always @(posedge clk or posedge mrst) begin
        if (mrst) begin
            acc0 <= 0;
            acc1 <= 0;
            for (int i = 0; i < int'(MAC_LAT); i++) begin
                pipe0[i] <= '0;
                pipe1[i] <= '0;
            end
        end else begin
            acc0     <= acc0 + p0;
            acc1     <= acc1 + p1;
            pipe0[0] <= enc(acc0 + p0);
            pipe1[0] <= enc(acc1 + p1);
            for (int i = 1; i < int'(MAC_LAT); i++) begin
                pipe0[i] <= pipe0[i-1];
                pipe1[i] <= pipe1[i-1];
            end
        end
    end

    assign facc0_in = pipe0[MAC_LAT-1];
    assign facc1_in = pipe1[MAC_LAT-1];

    // ---------------- checking ------------------------------------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- producer ------------------------------------------
    logic [15:0] feed_w [$];
    int          feed_at [$];
    bit          pend;
    logic [15:0] ops_log [64];

    // Called at a negedge: retire the word accepted at the previous edge and
    // present the next one once its release cycle has come.
    task automatic feed_step(input int k);
        if (pend) begin
            void'(feed_w.pop_front());
            void'(feed_at.pop_front());
        end
        if (feed_w.size() > 0 && k >= feed_at[0]) begin
            in_valid = 1'b1;
            in_data  = feed_w[0];
        end else begin
            in_valid = 1'b0;
        end
        pend = in_valid && in_ready;
    endtask

    task automatic prefill(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Issues start at the current negedge; k counts edges after the start
    // edge. Returns at the negedge where done is seen (or after the budget).
    task automatic run_job(input logic [7:0] jlen, input int restart_k,
                           output int done_k, output int clr_k, output int clr_n);
        done_k = -1;
        clr_k  = -1;
        clr_n  = 0;
        start  = 1'b1;
        len    = jlen;
        feed_step(-1);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            ops_log[k] = {a1, b1, a0, b0};
            if (mac_clr) begin
                if (clr_n == 0) clr_k = k;
                clr_n++;
            end
            if (done) begin
                done_k = k;
                break;
            end
            start = (k == restart_k);
            len   = (k == restart_k) ? 8'd5 : jlen;
            feed_step(k);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dk, ck, cn, dk_base;
        bit seen_done;

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; pend = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ops", {a1, b1, a0, b0}, 0);
        chk("rst_clr_done_res", {mac_clr, done, res1, res0}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Prefilled job, len=3, all ONE.
        repeat (3) prefill({FP4_ONE, FP4_ONE, FP4_ONE, FP4_ONE});
        run_job(8'd3, -1, dk, ck, cn);
        chk("t1_done_cycle", dk, 3 + MAC_LAT + 2);
        chk("t1_clr_cycle", ck, 0);
        chk("t1_clr_count", cn, 1);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_res0", res0, FP4_THREE);
        chk("t1_res1", res1, FP4_THREE);
        chk("t1_ops_k1", ops_log[1], 0);
        for (int k = 2; k <= 4; k++) chk("t1_ops_one", ops_log[k], 16'h2222);
        chk("t1_ops_k5", ops_log[5], 0);
        @(negedge clk);
        chk("t1_done_width", done, 0);

        // No-stall reference, len=4, lane0 1*1, lane1 1*1.5.
        repeat (4) prefill(16'h2322);
        run_job(8'd4, -1, dk_base, ck, cn);
        chk("t2a_done_cycle", dk_base, 4 + MAC_LAT + 2);
        chk("t2a_res0", res0, 4'b0110);
        chk("t2a_res1", res1, 4'b0111);
        @(negedge clk);

        // Same job with the producer idle for two cycles mid-stream.
        repeat (2) prefill(16'h2322);
        feed_w.push_back(16'h2322); feed_at.push_back(4);
        feed_w.push_back(16'h2322); feed_at.push_back(5);
        pend = 1'b0;
        run_job(8'd4, -1, dk, ck, cn);
        chk("t2b_done_delay", dk, dk_base + 2);
        chk("t2b_ops_k3", ops_log[3], 16'h2322);
        chk("t2b_bubble_k4", ops_log[4], 0);
        chk("t2b_bubble_k5", ops_log[5], 0);
        chk("t2b_ops_k6", ops_log[6], 16'h2322);
        chk("t2b_ops_k7", ops_log[7], 16'h2322);
        chk("t2b_res0", res0, 4'b0110);
        chk("t2b_res1", res1, 4'b0111);
        @(negedge clk);

        // Overfill: 4 words fit, the 5th is held by the producer.
        prefill(16'h0022);
        prefill(16'h0020);
        prefill(16'h2200);
        chk("t3_ready_after3", in_ready, 1);
        prefill(16'h2022);
        chk("t3_ready_after4", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 16'h0202;
        repeat (2) @(negedge clk);
        chk("t3_ready_held", in_ready, 0);
        feed_w.push_back(16'h0202); feed_at.push_back(-1);
        feed_w.push_back(16'h2222); feed_at.push_back(-1);
        pend = 1'b0;
        run_job(8'd6, -1, dk, ck, cn);
        chk("t3_done_cycle", dk, 6 + MAC_LAT + 2);
        chk("t3_ops_w1", ops_log[2], 16'h0022);
        chk("t3_ops_w2", ops_log[3], 16'h0020);
        chk("t3_ops_w3", ops_log[4], 16'h2200);
        chk("t3_ops_w4", ops_log[5], 16'h2022);
        chk("t3_ops_w5", ops_log[6], 16'h0202);
        chk("t3_ops_w6", ops_log[7], 16'h2222);
        chk("t3_res0", res0, FP4_THREE);
        chk("t3_res1", res1, FP4_TWO);
        @(negedge clk);

        // len=0 start is ignored; start while busy is ignored.
        prefill(16'h2222);
        start = 1'b1;
        len   = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t4_len0_state", {busy, mac_clr, done}, 0);
        repeat (2) @(negedge clk);
        chk("t4_len0_later", {busy, mac_clr, done, in_ready}, 1);
        run_job(8'd1, 2, dk, ck, cn);
        chk("t4_done_cycle", dk, 1 + MAC_LAT + 2);
        chk("t4_clr_count", cn, 1);
        chk("t4_res", {res1, res0}, {FP4_ONE, FP4_ONE});
        @(negedge clk);
        chk("t4_no_restart", {busy, done}, 0);

        // Reset in DRAIN.
        repeat (3) prefill(16'h2222);
        start = 1'b1;
        len   = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_busy_drain", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ops", {a1, b1, a0, b0}, 0);
        chk("t5_rst_clr_done_res", {mac_clr, done, res1, res0}, 0);
        chk("t5_rst_ready", in_ready, 1);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen_done |= done;
        end
        chk("t5_no_done", seen_done, 0);
        repeat (2) prefill({FP4_TWO, FP4_ONE, FP4_TWO, FP4_ONE});
        run_job(8'd2, -1, dk, ck, cn);
        chk("t5_done_cycle", dk, 2 + MAC_LAT + 2);
        chk("t5_res", {res1, res0}, 8'h66);

        // Back-to-back jobs, second start issued in the done cycle.
        @(negedge clk);
        repeat (2) prefill(16'h2222);
        repeat (2) prefill(16'h4242);
        run_job(8'd2, -1, dk, ck, cn);
        chk("t6a_done_cycle", dk, 2 + MAC_LAT + 2);
        chk("t6a_res", {res1, res0}, {FP4_TWO, FP4_TWO});
        chk("t6a_busy_at_done", busy, 0);
        run_job(8'd2, -1, dk, ck, cn);
        chk("t6b_clr_cycle", ck, 0);
        chk("t6b_done_cycle", dk, 2 + MAC_LAT + 2);
        chk("t6b_ops_k2", ops_log[2], 16'h4242);
        chk("t6b_res", {res1, res0}, 8'h66);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
